hog_tile_writer: RTL

//  Downstream of CHIP. Consumes one 3-row x 12-column tile of 12-bit HOG sqrt

---
 rtl/hog_tile_writer_pkg.sv | 33 +++
 rtl/hog_max12.sv | 28 ++
 rtl/hog_tile_writer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/hog_tile_writer_pkg.sv
// Shared definitions for the HOG tile writer.
// Geometry: 53 tiles per 3-row band, 160 bands per frame, 12 columns per tile,
// 12-bit magnitudes. Also holds the FSM state type and small helpers used by
// the top level and the max tree.
package hog_tile_writer_pkg;

  localparam int unsigned MAG_W          = 12;
  localparam int unsigned TILE_COLS      = 12;
  localparam int unsigned TILES_PER_BAND = 53;
  localparam int unsigned BANDS          = 160;
  localparam int unsigned ADDR_W         = 14;

  localparam int unsigned BANKS   = 3;
  localparam int unsigned ROW_W   = 3 * MAG_W;          // one block row: 3 pixels
  localparam int unsigned BLOCK_W = BANKS * ROW_W;      // 108
  localparam int unsigned BANK_W  = TILE_COLS * MAG_W;  // 144
  localparam int unsigned TILE_W  = $clog2(TILES_PER_BAND);
  localparam int unsigned BAND_W  = $clog2(BANDS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Row r of a CHIP block; row 0 sits in the top 36 bits.
  function automatic logic [ROW_W-1:0] row_slice(input logic [BLOCK_W-1:0] blk,
                                                 input int unsigned r);
    return blk[BLOCK_W-1-ROW_W*r -: ROW_W];
  endfunction

  function automatic logic [MAG_W-1:0] max2(input logic [MAG_W-1:0] a,
                                            input logic [MAG_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hog_max12.sv
// Combinational unsigned maximum over 12 magnitudes with per-input enable.
// Disabled inputs contribute 0, the identity for an unsigned max.
//  data    : 12 packed magnitudes, input i at data[MAG_W*i +: MAG_W]
//  en      : enable per input, bit i qualifies input i
//  max_val : maximum over enabled inputs (0 when none enabled)
module hog_max12
  import hog_tile_writer_pkg::*;
(
  input  logic [TILE_COLS*MAG_W-1:0] data,
  input  logic [TILE_COLS-1:0]       en,
  output logic [MAG_W-1:0]           max_val
);

  logic [MAG_W-1:0] l0 [12];
  logic [MAG_W-1:0] l1 [6];
  logic [MAG_W-1:0] l2 [3];

  always_comb begin
    for (int unsigned i = 0; i < 12; i++)
      l0[i] = en[i] ? data[MAG_W*i +: MAG_W] : '0;
    for (int unsigned i = 0; i < 6; i++)
      l1[i] = max2(l0[2*i], l0[2*i+1]);
    for (int unsigned i = 0; i < 3; i++)
      l2[i] = max2(l1[2*i], l1[2*i+1]);
    max_val = max2(max2(l2[0], l2[1]), l2[2]);
  end

endmodule

// File: rtl/hog_tile_writer.sv
// Writes 3x12 HOG magnitude tiles from CHIP into three row-interleaved SRAM
// banks in frame raster order, masking non-existent edge pixels, and reports
// frame completion together with the frame maximum.
//  clk, rst_n             : clock, asynchronous active-low reset
//  valid, mode            : one tile per valid cycle; mode latched at frame start
//  block_out_0..3         : four 3x3 blocks, block 0 holds the highest columns
//  bank_we/addr/wdata/wmask : registered bank write, bank k in the k-th slice
//  frame_mode             : mode of the current frame
//  frame_done, frame_max  : end-of-frame pulse and max of unmasked pixels
module hog_tile_writer
  import hog_tile_writer_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid,
  input  logic                       mode,
  input  logic [BLOCK_W-1:0]         block_out_0,
  input  logic [BLOCK_W-1:0]         block_out_1,
  input  logic [BLOCK_W-1:0]         block_out_2,
  input  logic [BLOCK_W-1:0]         block_out_3,
  output logic [BANKS-1:0]           bank_we,
  output logic [ADDR_W-1:0]          bank_addr,
  output logic [BANKS*BANK_W-1:0]    bank_wdata,
  output logic [BANKS*TILE_COLS-1:0] bank_wmask,
  output logic                       frame_mode,
  output logic                       frame_done,
  output logic [MAG_W-1:0]           frame_max
);

  localparam logic [TILE_W-1:0] LAST_TILE = TILE_W'(TILES_PER_BAND - 1);
  localparam logic [BAND_W-1:0] LAST_BAND = BAND_W'(BANDS - 1);

  state_t              state;
  logic [BAND_W-1:0]   band_q;
  logic [TILE_W-1:0]   tile_q;
  logic [ADDR_W-1:0]   addr_q;

  logic                 start;
  logic                 last;
  logic [BAND_W-1:0]    cur_band;
  logic [TILE_W-1:0]    cur_tile;
  logic [ADDR_W-1:0]    cur_addr;
  logic [BANK_W-1:0]    word   [BANKS];
  logic [TILE_COLS-1:0] mask_c [BANKS];
  logic [MAG_W-1:0]     bmax   [BANKS];
  logic [BANKS*BANK_W-1:0]    wdata_c;
  logic [BANKS*TILE_COLS-1:0] wmask_c;
  logic [MAG_W-1:0]     tile_max;
  logic [MAG_W-1:0]     next_max;

  // Outside RUN the incoming tile is always tile 0 of band 0, so the
  // position is forced to zero instead of relying on the counters.
  always_comb begin
    start    = (state != RUN);
    cur_band = start ? '0 : band_q;
    cur_tile = start ? '0 : tile_q;
    cur_addr = start ? '0 : addr_q;
    last     = (cur_band == LAST_BAND) && (cur_tile == LAST_TILE);

    wdata_c = '0;
    wmask_c = '0;
    for (int unsigned r = 0; r < BANKS; r++) begin
      word[r] = {row_slice(block_out_0, r), row_slice(block_out_1, r),
                 row_slice(block_out_2, r), row_slice(block_out_3, r)};
      mask_c[r] = '1;
      // Band 0, bank 0 is image row -1.
      if (cur_band == '0 && r == 0)
        mask_c[r] = '0;
      // Tile 0 starts at column 636; columns 636 and 635 are off-image.
      if (cur_tile == '0)
        mask_c[r][TILE_COLS-1 -: 2] = 2'b00;
      wdata_c[BANK_W*r +: BANK_W]       = word[r];
      wmask_c[TILE_COLS*r +: TILE_COLS] = mask_c[r];
    end

    tile_max = max2(max2(bmax[0], bmax[1]), bmax[2]);
    next_max = start ? tile_max : max2(frame_max, tile_max);
  end

  for (genvar g = 0; g < BANKS; g++) begin : g_bank_max
    hog_max12 u_max (
      .data    (word[g]),
      .en      (mask_c[g]),
      .max_val (bmax[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      band_q     <= '0;
      tile_q     <= '0;
      addr_q     <= '0;
      bank_we    <= '0;
      bank_addr  <= '0;
      bank_wdata <= '0;
      bank_wmask <= '0;
      frame_mode <= 1'b0;
      frame_done <= 1'b0;
      frame_max  <= '0;
    end else begin
      bank_we    <= '0;
      frame_done <= 1'b0;
      if (valid) begin
        bank_we    <= '1;
        bank_addr  <= cur_addr;
        bank_wdata <= wdata_c;
        bank_wmask <= wmask_c;
        frame_max  <= next_max;
        if (start)
          frame_mode <= mode;
        addr_q <= cur_addr + 1'b1;
        if (cur_tile == LAST_TILE) begin
          tile_q <= '0;
          band_q <= cur_band + 1'b1;
        end else begin
          tile_q <= cur_tile + 1'b1;
          band_q <= cur_band;
        end
        if (last) begin
          state      <= DONE;
          frame_done <= 1'b1;
        end else begin
          state <= RUN;
        end
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end

endmodule
